// File: rtl/pixel_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_scan_pkg
// Description : Shared types, geometry constants and the one-hot decoder
//               function for the 3x3 pixel frame capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_scan_pkg;

  localparam int NROWS = 3;
  localparam int NCOLS = 3;
  localparam int NPIX  = NROWS * NCOLS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } onehot_idx_t;

  function automatic onehot_idx_t onehot_to_idx(input logic [2:0] oh);
    onehot_idx_t res;
    res.valid = 1'b1;
    res.idx   = 2'd0;
    case (oh)
      3'b001:  res.idx = 2'd0;
      3'b010:  res.idx = 2'd1;
      3'b100:  res.idx = 2'd2;
      default: res.valid = 1'b0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : pixel_onehot_dec
// Description : Validates a 3-bit one-hot select and encodes it to an index.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_onehot_dec
  import pixel_scan_pkg::*;
(
  input  logic [2:0] oh_i,
  output logic [1:0] idx_o,
  output logic       valid_o
);

  onehot_idx_t w_dec;

  assign w_dec   = onehot_to_idx(oh_i);
  assign idx_o   = w_dec.idx;
  assign valid_o = w_dec.valid;

endmodule
`default_nettype wire

// File: rtl/pixel_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : pixel_frame_capture
// Description : Captures a 3x3 scanned frame into a buffer and drains it as a
//               valid/ready pixel stream. Define PIXEL_CAPTURE_ERRCNT_EN to
//               add the saturating err_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_frame_capture
  import pixel_scan_pkg::*;
#(
  parameter int PIX_W = 12
) (
  input  logic             clk,
  input  logic             master_rst_n,
  input  logic             fsync,
  input  logic             intg,
  input  logic [2:0]       row,
  input  logic [2:0]       col,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data,
  output logic [1:0]       out_row,
  output logic [1:0]       out_col,
  output logic             out_last,
  output logic             frame_done,
`ifdef PIXEL_CAPTURE_ERRCNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic             err_proto,
  output logic             err_overrun
);

  localparam logic [NPIX-1:0] MASK_ONE = {{(NPIX-1){1'b0}}, 1'b1};

  cap_state_e       state_q, state_d;
  logic             intg_q;
  logic [NPIX-1:0]  mask_q, mask_d;
  logic [3:0]       idx_q, idx_d;
  logic [PIX_W-1:0] pix_buf_q [NPIX];

  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic [1:0]       out_row_q, out_row_d;
  logic [1:0]       out_col_q, out_col_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;
  logic             err_proto_q, err_proto_d;
  logic             err_overrun_q, err_overrun_d;

  logic [1:0]       w_row_idx, w_col_idx;
  logic             w_row_ok, w_col_ok;
  logic             w_cap_en, w_drain_en, w_enter_armed;
  logic             w_strobe, w_coord_ok, w_dup, w_good_wr, w_bad_strobe;
  logic [3:0]       w_pix;
  logic             w_fall, w_incomplete, w_fsync_restart, w_fsync_overrun;
  logic [NPIX-1:0]  w_mask_upd;
  logic             w_xfer, w_last_xfer, w_load;
  logic [1:0]       w_ld_row, w_ld_col;

  pixel_onehot_dec u_row_dec (
    .oh_i    (row),
    .idx_o   (w_row_idx),
    .valid_o (w_row_ok)
  );

  pixel_onehot_dec u_col_dec (
    .oh_i    (col),
    .idx_o   (w_col_idx),
    .valid_o (w_col_ok)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  // FSM: next state; fsync restarts any frame still being captured
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (fsync) state_d = ST_ARMED;
      ST_ARMED:   if (fsync) state_d = ST_ARMED;
                  else if (intg) state_d = ST_CAPTURE;
      ST_CAPTURE: if (fsync) state_d = ST_ARMED;
                  else if (w_fall) state_d = ST_DRAIN;
      ST_DRAIN:   if (w_last_xfer) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM: per-state controls
  always_comb begin
    w_cap_en      = (state_q == ST_CAPTURE) && !fsync;
    w_drain_en    = (state_q == ST_DRAIN);
    w_enter_armed = fsync && (state_q != ST_DRAIN);
  end

  assign w_strobe        = w_cap_en && (col != 3'b000);
  assign w_coord_ok      = w_row_ok && w_col_ok;
  assign w_pix           = 4'(w_row_idx) * 4'd3 + 4'(w_col_idx);
  assign w_dup           = w_coord_ok && mask_q[w_pix];
  assign w_good_wr       = w_strobe && w_coord_ok && !w_dup;
  assign w_bad_strobe    = w_strobe && !w_good_wr;
  assign w_fall          = intg_q && !intg;
  assign w_mask_upd      = w_good_wr ? (mask_q | (MASK_ONE << w_pix)) : mask_q;
  assign w_incomplete    = w_cap_en && w_fall && (w_mask_upd != {NPIX{1'b1}});
  assign w_fsync_restart = w_enter_armed && (state_q != ST_IDLE);
  assign w_fsync_overrun = fsync && w_drain_en;

  assign w_xfer      = out_valid_q && out_ready;
  assign w_last_xfer = w_xfer && out_last_q;
  assign w_load      = w_drain_en && (idx_q < 4'(NPIX)) && (!out_valid_q || out_ready);

  always_comb begin
    if (idx_q >= 4'd6) begin
      w_ld_row = 2'd2;
      w_ld_col = 2'(idx_q - 4'd6);
    end else if (idx_q >= 4'd3) begin
      w_ld_row = 2'd1;
      w_ld_col = 2'(idx_q - 4'd3);
    end else begin
      w_ld_row = 2'd0;
      w_ld_col = idx_q[1:0];
    end
  end

  always_comb begin
    mask_d        = w_enter_armed ? '0 : w_mask_upd;
    idx_d         = idx_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_row_d     = out_row_q;
    out_col_d     = out_col_q;
    out_last_d    = out_last_q;
    frame_done_d  = w_last_xfer;
    err_proto_d   = err_proto_q | w_bad_strobe | w_incomplete | w_fsync_restart;
    err_overrun_d = err_overrun_q | w_fsync_overrun;
    if (!w_drain_en) begin
      idx_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (w_load) begin
      // Pixels never strobed this frame drain as zero
      idx_d       = idx_q + 4'd1;
      out_valid_d = 1'b1;
      out_data_d  = mask_q[idx_q] ? pix_buf_q[idx_q] : '0;
      out_row_d   = w_ld_row;
      out_col_d   = w_ld_col;
      out_last_d  = (idx_q == 4'(NPIX - 1));
    end else if (w_last_xfer) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      intg_q        <= 1'b0;
      mask_q        <= '0;
      idx_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_row_q     <= '0;
      out_col_q     <= '0;
      out_last_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      err_proto_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      intg_q        <= intg;
      mask_q        <= mask_d;
      idx_q         <= idx_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_row_q     <= out_row_d;
      out_col_q     <= out_col_d;
      out_last_q    <= out_last_d;
      frame_done_q  <= frame_done_d;
      err_proto_q   <= err_proto_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // Pixel storage is deliberately left out of reset; the mask qualifies it
  always_ff @(posedge clk) begin
    if (w_good_wr) pix_buf_q[w_pix] <= pix_data;
  end

`ifdef PIXEL_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [2:0] w_evt_num;
  logic [8:0] w_cnt_sum;

  assign w_evt_num = 3'(w_bad_strobe) + 3'(w_incomplete)
                   + 3'(w_fsync_restart) + 3'(w_fsync_overrun);
  assign w_cnt_sum = {1'b0, err_cnt_q} + {6'd0, w_evt_num};
  assign err_cnt_d = w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];

  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) err_cnt_q <= '0;
    else               err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;
  assign out_last    = out_last_q;
  assign frame_done  = frame_done_q;
  assign err_proto   = err_proto_q;
  assign err_overrun = err_overrun_q;

endmodule
`default_nettype wire
